// File: rtl/mandelbrot_iter_ctrl.sv
// Iteration sequencer for the Mandelbrot ALU: latches a point c, steps z through the external
// ALU once per cycle and reports the escape iteration count over a valid/ready handshake.
module mandelbrot_iter_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ITER_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_cr,
    input  logic [WIDTH-1:0]      in_ci,
    input  logic [ITER_WIDTH-1:0] max_iter,

    output logic [WIDTH-1:0]      alu_cr,
    output logic [WIDTH-1:0]      alu_ci,
    output logic [WIDTH-1:0]      alu_zr,
    output logic [WIDTH-1:0]      alu_zi,
    input  logic [WIDTH-1:0]      alu_next_zr,
    input  logic [WIDTH-1:0]      alu_next_zi,
    input  logic                  alu_size,
    input  logic                  alu_overflow,

    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ITER_WIDTH-1:0] out_iter,
    output logic                  out_escaped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [ITER_WIDTH-1:0]   iter_cnt;
    logic [ITER_WIDTH-1:0]   limit;
    logic                    escape;

    assign escape = alu_size | alu_overflow;

    // Handshake flags are registered alongside the state so every output is a flop output.
    // The limit compare precedes the increment, so iter_cnt can never wrap past max_iter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_iter    <= '0;
            out_escaped <= 1'b0;
            alu_cr      <= '0;
            alu_ci      <= '0;
            alu_zr      <= '0;
            alu_zi      <= '0;
            iter_cnt    <= '0;
            limit       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_cr   <= in_cr;
                        alu_ci   <= in_ci;
                        limit    <= max_iter;
                        alu_zr   <= '0;
                        alu_zi   <= '0;
                        iter_cnt <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (escape) begin
                        out_iter    <= iter_cnt;
                        out_escaped <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (iter_cnt == limit) begin
                        out_iter    <= iter_cnt;
                        out_escaped <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        alu_zr   <= alu_next_zr;
                        alu_zi   <= alu_next_zi;
                        iter_cnt <= iter_cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
